// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs LSB-first bytes into words
// and writes them at consecutive word addresses.
module imem_loader #(
    parameter int address_size = 32,
    parameter int word_size    = 32,
    parameter int n_words      = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    byte_last,
    output logic                    byte_ready,
    output logic                    mem_we,
    output logic [address_size-1:0] mem_address,
    output logic [word_size-1:0]    mem_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [address_size-1:0] word_count
);

    localparam int BPW   = word_size / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(BPW - 1);
    localparam logic [address_size-1:0] N_WORDS_A = address_size'(n_words);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [word_size-1:0]    asm_q, asm_d;
    logic                    last_q, last_d;
    logic [address_size-1:0] wc_q, wc_d;
    logic                    overflow_q, overflow_d;
    logic                    mem_we_q, mem_we_d;
    logic [address_size-1:0] mem_addr_q, mem_addr_d;
    logic [word_size-1:0]    mem_data_q, mem_data_d;
    logic [word_size-1:0]    filled;

    // Assembler is cleared between words, so OR-ing leaves unfilled bytes zero.
    assign filled = asm_q | (word_size'(byte_in) << {idx_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        last_d     = last_q;
        wc_d       = wc_q;
        overflow_d = overflow_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    idx_d      = '0;
                    asm_d      = '0;
                    last_d     = 1'b0;
                    wc_d       = '0;
                    overflow_d = 1'b0;
                end
            end
            LOAD: begin
                if (byte_valid) begin
                    asm_d = filled;
                    if (idx_q == LAST_IDX || byte_last) begin
                        state_d = WRITE;
                        last_d  = byte_last;
                        // Output registers only move on a real write, so they hold otherwise.
                        if (wc_q < N_WORDS_A) begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = wc_q;
                            mem_data_d = filled;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_we_q) begin
                    wc_d = wc_q + 1'b1;
                end
                idx_d   = '0;
                asm_d   = '0;
                state_d = last_q ? DONE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            asm_q      <= '0;
            last_q     <= 1'b0;
            wc_q       <= '0;
            overflow_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            last_q     <= last_d;
            wc_q       <= wc_d;
            overflow_q <= overflow_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign byte_ready  = (state_q == LOAD);
    assign busy        = (state_q == LOAD) || (state_q == WRITE);
    assign done        = (state_q == DONE);
    assign mem_we      = mem_we_q;
    assign mem_address = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign overflow    = overflow_q;
    assign word_count  = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default-depth instance and a 2-word instance share
// one byte stream; both are checked against a word-image model of the stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid, byte_last;
    logic [7:0]  byte_in;

    logic        a_ready, a_we, a_busy, a_done, a_ovf;
    logic [31:0] a_addr, a_data, a_wc;
    logic        b_ready, b_we, b_busy, b_done, b_ovf;
    logic [31:0] b_addr, b_data, b_wc;

    int checks = 0;
    int errors = 0;
    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];

    imem_loader dut_a (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(a_ready),
        .mem_we(a_we), .mem_address(a_addr), .mem_data(a_data), .busy(a_busy),
        .done(a_done), .overflow(a_ovf), .word_count(a_wc)
    );

    imem_loader #(.n_words(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(b_ready),
        .mem_we(b_we), .mem_address(b_addr), .mem_data(b_data), .busy(b_busy),
        .done(b_done), .overflow(b_ovf), .word_count(b_wc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_we) wq_a.push_back({a_addr, a_data});
        if (b_we) wq_b.push_back({b_addr, b_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word k of the program image: bytes 4k..4k+3, little endian, zero padded.
    function automatic logic [31:0] exp_word(input logic [7:0] bytes[$], input int k);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++)
            if (4 * k + b < bytes.size()) w[8*b +: 8] = bytes[4*k + b];
        return w;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, {a_ready, b_ready}, 2'b00);
        chk({tag, "_we"},    {a_we, b_we}, 2'b00);
        chk({tag, "_addr"},  {a_addr, b_addr}, 64'h0);
        chk({tag, "_data"},  {a_data, b_data}, 64'h0);
        chk({tag, "_busy"},  {a_busy, b_busy}, 2'b00);
        chk({tag, "_done"},  {a_done, b_done}, 2'b00);
        chk({tag, "_ovf"},   {a_ovf, b_ovf}, 2'b00);
        chk({tag, "_wc"},    {a_wc, b_wc}, 64'h0);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (a_ready) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout observed=ready_low expected=ready_high");
                break;
            end
        end
        step();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [7:0] bytes[$],
                            input bit gaps, input bit noise);
        int nw, nb, n;
        logic [31:0] w;
        logic last;
        nw = (bytes.size() + 3) / 4;
        nb = (nw < 2) ? nw : 2;
        wq_a.delete();
        wq_b.delete();
        pulse_start();
        chk({tag, "_start_state"}, {a_busy, a_done, b_done, b_ovf}, 4'b1000);
        chk({tag, "_start_wc"}, {a_wc, b_wc}, 64'h0);
        for (int i = 0; i < bytes.size(); i++) begin
            last = (i == bytes.size() - 1);
            send(bytes[i], last);
            if (i % 4 == 3 || last) begin
                w = exp_word(bytes, i / 4);
                chk({tag, "_we_a"}, a_we, 1'b1);
                chk({tag, "_wr_a"}, {a_addr, a_data}, {32'(i / 4), w});
                chk({tag, "_we_b"}, b_we, (i / 4) < 2);
                if (i / 4 < 2) chk({tag, "_wr_b"}, {b_addr, b_data}, {32'(i / 4), w});
                else chk({tag, "_ovf_b"}, b_ovf, 1'b1);
            end
            if (!last && gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    if (noise && $urandom_range(0, 1) == 1) start = 1'b1;
                    step();
                    start = 1'b0;
                end
            end
        end
        n = 0;
        while (!a_done && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_done"}, {a_done, b_done, a_busy, a_ready, a_we}, 5'b11000);
        chk({tag, "_wc_a"}, a_wc, 32'(nw));
        chk({tag, "_ovf_a"}, a_ovf, 1'b0);
        chk({tag, "_wc_b"}, b_wc, 32'(nb));
        chk({tag, "_ovf_b_end"}, b_ovf, nw > 2);
        chk({tag, "_hold_a"}, {a_addr, a_data}, {32'(nw - 1), exp_word(bytes, nw - 1)});
        chk({tag, "_hold_b"}, {b_addr, b_data}, {32'(nb - 1), exp_word(bytes, nb - 1)});
        chk({tag, "_nwr_a"}, 32'(wq_a.size()), 32'(nw));
        chk({tag, "_nwr_b"}, 32'(wq_b.size()), 32'(nb));
        for (int j = 0; j < wq_a.size() && j < nw; j++)
            chk({tag, "_img_a"}, wq_a[j], {32'(j), exp_word(bytes, j)});
        for (int j = 0; j < wq_b.size() && j < nb; j++)
            chk({tag, "_img_b"}, wq_b[j], {32'(j), exp_word(bytes, j)});
        step();
        chk({tag, "_stable"}, {a_done, a_wc, b_ovf}, {1'b1, 32'(nw), nw > 2});
    endtask

    initial begin
        logic [7:0] q[$];
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h0;
        repeat (3) step();
        reset = 1'b0;
        check_zero("por");

        q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load("two_words", q, 1'b0, 1'b0);

        q = '{8'hAA, 8'hBB};
        run_load("short", q, 1'b0, 1'b0);

        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        run_load("overflow", q, 1'b0, 1'b0);

        q = '{8'h5A, 8'hC3, 8'h99, 8'h11, 8'h42};
        run_load("restart", q, 1'b0, 1'b0);

        pulse_start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check_zero("midword_reset");

        q = '{8'h9C, 8'h8B, 8'h7A, 8'h69, 8'h58};
        run_load("after_reset", q, 1'b0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            q.delete();
            repeat ($urandom_range(1, 14)) q.push_back(8'($urandom));
            run_load("random", q, 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
